// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: buffer state encoding,
// flag bit positions and the default datapath width.
package alu_pkg;

  localparam int unsigned ALU_DEFAULT_WIDTH = 16;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/alu_flag_reg.sv
// Architectural {N,Z,C,V} flag register with clear; a load beats a clear.
// Optional sticky overflow bit under ALU_STICKY_OVERFLOW_EN.
module alu_flag_reg
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] flags_d,
  input  logic       clr,
`ifdef ALU_STICKY_OVERFLOW_EN
  output logic       sticky_v,
`endif
  output logic [3:0] flags_q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (load) begin
      flags_q <= flags_d;
    end else if (clr) begin
      flags_q <= '0;
    end
  end

`ifdef ALU_STICKY_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_v <= 1'b0;
    end else if (load && flags_d[FLAG_V]) begin
      sticky_v <= 1'b1;
    end else if (clr) begin
      sticky_v <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry (main + skid) FIFO with registered in_ready,
// plus flag register. Optional sticky overflow via ALU_STICKY_OVERFLOW_EN.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_DEFAULT_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_negative,
  input  logic             in_zero,
  input  logic             in_cout,
  input  logic             in_overflow,
  input  logic             in_flag_we,
  input  logic             flags_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [3:0]       out_flags,
`ifdef ALU_STICKY_OVERFLOW_EN
  output logic             sticky_v,
`endif
  output logic [3:0]       flags_q
);

  buf_state_t state, state_nxt;
  logic [WIDTH-1:0] mem_y     [DEPTH];
  logic [3:0]       mem_flags [DEPTH];
  logic [3:0]       in_flags;
  logic             push, pop;

  always_comb begin
    in_flags         = '0;
    in_flags[FLAG_N] = in_negative;
    in_flags[FLAG_Z] = in_zero;
    in_flags[FLAG_C] = in_cout;
    in_flags[FLAG_V] = in_overflow;
  end

  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_y     = mem_y[0];
  assign out_flags = mem_flags[0];

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Entry 0 always presents the oldest word; entry DEPTH-1 is the skid slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_y[i]     <= '0;
        mem_flags[i] <= '0;
      end
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
      case (state)
        EMPTY: begin
          if (push) begin
            mem_y[0]     <= in_y;
            mem_flags[0] <= in_flags;
          end
        end
        ONE: begin
          if (push && pop) begin
            mem_y[0]     <= in_y;
            mem_flags[0] <= in_flags;
          end else if (push) begin
            mem_y[DEPTH-1]     <= in_y;
            mem_flags[DEPTH-1] <= in_flags;
          end
        end
        FULL: begin
          if (pop) begin
            mem_y[0]     <= mem_y[DEPTH-1];
            mem_flags[0] <= mem_flags[DEPTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  alu_flag_reg u_flag_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (push && in_flag_we),
    .flags_d (in_flags),
    .clr     (flags_clr),
`ifdef ALU_STICKY_OVERFLOW_EN
    .sticky_v(sticky_v),
`endif
    .flags_q (flags_q)
  );

endmodule
